// File: rtl/vga_bar_if.sv
// Video-side bundle for vga_bar_engine: packed channel input plus registered sync/colour/strobe outputs.
interface vga_bar_if #(
  parameter int N_CH    = 10,
  parameter int CH_W    = 20,
  parameter int COLOR_W = 4
);
  logic [N_CH*CH_W-1:0] num;
  logic                 hsync_r;
  logic                 vsync_r;
  logic [COLOR_W-1:0]   OutRed;
  logic [COLOR_W-1:0]   OutGreen;
  logic [COLOR_W-1:0]   OutBlue;
  logic                 pix_stb;
  logic                 frame_start;

  modport master (
    input  num,
    output hsync_r, vsync_r, OutRed, OutGreen, OutBlue, pix_stb, frame_start
  );

  modport slave (
    output num,
    input  hsync_r, vsync_r, OutRed, OutGreen, OutBlue, pix_stb, frame_start
  );
endinterface

// File: rtl/vga_bar_engine.sv
// VGA timing on a pixel strobe, rendering N_CH snapshotted channels as horizontal bar stripes.
// Optional macro VGA_BORDER_EN paints a one-pixel white frame around the active area.
module vga_bar_engine #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_NEG = 1,
  parameter int N_CH     = 10,
  parameter int CH_W     = 20,
  parameter int COLOR_W  = 4
) (
  input  logic      clk,
  input  logic      rst,
  vga_bar_if.master bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int STRIPE_H = V_ACTIVE / N_CH;
  localparam int DW       = $clog2(CLK_DIV);
  localparam int HW       = $clog2(H_TOTAL + 1);
  localparam int VW       = $clog2(V_TOTAL + 1);
  localparam int RW       = $clog2(STRIPE_H + 1);
  localparam int SW       = $clog2(N_CH + 1);
  localparam int CW       = (HW > CH_W) ? HW : CH_W;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_BAR      = VW'(N_CH * STRIPE_H);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [RW-1:0] ROW_LAST   = RW'(STRIPE_H - 1);
  localparam logic [SW-1:0] S_CAP      = SW'(N_CH);
  localparam logic          SYNC_OFF   = (SYNC_NEG != 0);

  logic [DW-1:0]        r_div;
  logic [HW-1:0]        r_h;
  logic [VW-1:0]        r_v;
  logic [RW-1:0]        r_row;
  logic [SW-1:0]        r_stripe;
  logic [N_CH*CH_W-1:0] r_snap;
  logic                 r_hsync;
  logic                 r_vsync;
  logic [COLOR_W-1:0]   r_red;
  logic [COLOR_W-1:0]   r_green;
  logic [COLOR_W-1:0]   r_blue;
  logic                 r_pix_stb;
  logic                 r_frame_start;

  logic                 w_stb;
  logic                 w_h_wrap;
  logic                 w_v_wrap;
  logic                 w_hs_act;
  logic                 w_vs_act;
  logic [CH_W-1:0]      w_chan;
  logic                 w_on;
  logic [COLOR_W-1:0]   w_red;
  logic [COLOR_W-1:0]   w_green;
  logic [COLOR_W-1:0]   w_blue;

  assign w_stb    = (r_div == DIV_LAST);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_hs_act = (r_h >= HS_BEG) && (r_h < HS_END);
  assign w_vs_act = (r_v >= VS_BEG) && (r_v < VS_END);

  // Stripe index saturates at N_CH below the bars, which selects no channel.
  always_comb begin
    w_chan = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_stripe == SW'(k)) w_chan = r_snap[k*CH_W +: CH_W];
    end
  end

  assign w_on = (r_h < H_ACT) && (r_v < V_BAR) && (r_row != ROW_LAST)
              && (CW'(r_h) < CW'(w_chan));

  always_comb begin
    w_red   = '0;
    w_green = (w_on && !r_stripe[0]) ? {COLOR_W{1'b1}} : '0;
    w_blue  = (w_on &&  r_stripe[0]) ? {COLOR_W{1'b1}} : '0;
`ifdef VGA_BORDER_EN
    if ((r_h < H_ACT) && (r_v < V_ACT)
        && (r_h == '0 || r_h == H_ACT_LAST || r_v == '0 || r_v == V_ACT_LAST)) begin
      w_red   = {COLOR_W{1'b1}};
      w_green = {COLOR_W{1'b1}};
      w_blue  = {COLOR_W{1'b1}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_row         <= '0;
      r_stripe      <= '0;
      r_snap        <= '0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_pix_stb     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_stb     <= w_stb;
      r_frame_start <= w_stb && w_h_wrap && w_v_wrap;
      r_div         <= w_stb ? '0 : r_div + 1'b1;
      if (w_stb) begin
        r_hsync <= SYNC_OFF ^ w_hs_act;
        r_vsync <= SYNC_OFF ^ w_vs_act;
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
        r_h     <= w_h_wrap ? '0 : r_h + 1'b1;
        if (w_h_wrap) begin
          r_v <= w_v_wrap ? '0 : r_v + 1'b1;
          if (w_v_wrap || r_row == ROW_LAST) r_row <= '0;
          else                               r_row <= r_row + 1'b1;
          if (w_v_wrap)                                     r_stripe <= '0;
          else if (r_row == ROW_LAST && r_stripe != S_CAP) r_stripe <= r_stripe + 1'b1;
        end
        // Latched at the start of vertical blank so the next frame never tears.
        if (r_h == '0 && r_v == V_ACT) r_snap <= bus.num;
      end
    end
  end

  assign bus.hsync_r     = r_hsync;
  assign bus.vsync_r     = r_vsync;
  assign bus.OutRed      = r_red;
  assign bus.OutGreen    = r_green;
  assign bus.OutBlue     = r_blue;
  assign bus.pix_stb     = r_pix_stb;
  assign bus.frame_start = r_frame_start;
endmodule
